// File: rtl/dz_pkg.sv
// Shared types and constants for the dot-matrix scan decoder: glyph planes,
// colour/number codes and the frame-assembly state type.
package dz_pkg;

   // One display plane: element i is row i, bit 7 of each byte is the leftmost column.
   typedef logic [7:0][7:0] plane_t;
   typedef logic [6:0][7:0] partial_t;
   typedef logic [2:0]      num_t;

   typedef enum logic [1:0] {
      COL_OFF = 2'b00,
      COL_RED = 2'b01,
      COL_GRN = 2'b10,
      COL_YEL = 2'b11
   } color_t;

   typedef enum logic {
      ST_HUNT     = 1'b0,
      ST_ASSEMBLE = 1'b1
   } state_t;

   typedef struct packed {
      num_t   num;
      color_t color;
   } cand_t;

   localparam num_t NUM_BLANK   = 3'd0;
   localparam num_t NUM_UNKNOWN = 3'd7;

   localparam plane_t GLYPH1 = 64'h7E60_300C_0666_3C00;
   localparam plane_t GLYPH2 = 64'h3C66_061C_0666_3C00;
   localparam plane_t GLYPH3 = 64'h0C0C_7E4C_2C1C_0C00;
   localparam plane_t GLYPH4 = 64'h3C66_0606_7C60_7E00;

   function automatic num_t glyph_code(input plane_t lit);
      if      (lit == GLYPH1) glyph_code = 3'd1;
      else if (lit == GLYPH2) glyph_code = 3'd2;
      else if (lit == GLYPH3) glyph_code = 3'd3;
      else if (lit == GLYPH4) glyph_code = 3'd4;
      else                    glyph_code = NUM_UNKNOWN;
   endfunction

   // Index of the selected row; only meaningful when exactly one bit is set.
   function automatic logic [2:0] onehot_index(input logic [7:0] sel);
      onehot_index = '0;
      for (int i = 0; i < 8; i++) begin
         if (sel[i]) onehot_index = 3'(i);
      end
   endfunction

endpackage

// File: rtl/dz_scan_decoder_if.sv
// Scan-bus and result signals of the dot-matrix decoder; the driver side is
// the master, the decoder is the slave.
interface dz_scan_decoder_if;
   logic       scan_en;
   logic [7:0] row_in;
   logic [7:0] colr_in;
   logic [7:0] colg_in;
   logic [2:0] num_out;
   logic [1:0] color_out;
   logic       num_valid;
   logic       frame_done;
   logic       err_row;
   logic       err_seq;

   modport master (
      output scan_en, row_in, colr_in, colg_in,
      input  num_out, color_out, num_valid, frame_done, err_row, err_seq
   );

   modport slave (
      input  scan_en, row_in, colr_in, colg_in,
      output num_out, color_out, num_valid, frame_done, err_row, err_seq
   );
endinterface

// File: rtl/dz_glyph_match.sv
// Combinational classifier: turns a red and a green plane into a candidate
// number and colour.
module dz_glyph_match
   import dz_pkg::*;
(
   input  plane_t red_plane,
   input  plane_t grn_plane,
   output num_t   cand_num,
   output color_t cand_color
);

   logic red_on;
   logic grn_on;

   assign red_on = |red_plane;
   assign grn_on = |grn_plane;

   // NOTE: every output gets a default at the top so no path leaves it unassigned and infers a latch.
   always_comb begin
      cand_num   = NUM_UNKNOWN;
      cand_color = COL_YEL;
      if (!red_on && !grn_on) begin
         cand_num   = NUM_BLANK;
         cand_color = COL_OFF;
      end else if (red_on && grn_on && (red_plane != grn_plane)) begin
         cand_num   = NUM_UNKNOWN;
         cand_color = COL_YEL;
      end else begin
         // Both planes lit means they are identical here, so either one is the glyph.
         cand_num   = glyph_code(red_on ? red_plane : grn_plane);
         cand_color = (red_on && grn_on) ? COL_YEL : (red_on ? COL_RED : COL_GRN);
      end
   end

endmodule

// File: rtl/dz_scan_decoder.sv
// Rebuilds 8x8 red/green frames from the row-strobe scan bus, classifies them
// and publishes the number/colour once it has been stable for STABLE_FRAMES.
module dz_scan_decoder
   import dz_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES = 2
) (
   input  logic               clk,
   input  logic               rst,
   dz_scan_decoder_if.slave   bus
);

   localparam logic [2:0] STABLE_CNT = 3'(STABLE_FRAMES);

   state_t     state_q, state_d;
   logic [2:0] exp_q, exp_d;
   partial_t   red_buf_q, red_buf_d;
   partial_t   grn_buf_q, grn_buf_d;
   cand_t      cand_q, cand_d;
   cand_t      prev_q, prev_d;
   cand_t      out_q, out_d;
   logic [2:0] cnt_q, cnt_d;
   logic       valid_q, valid_d;
   logic       frame_done_q, frame_done_d;
   logic       err_row_q, err_row_d;
   logic       err_seq_q, err_seq_d;

   logic [7:0] row_sel;
   logic       row_blank;
   logic       row_multi;
   logic [2:0] row_idx;
   logic       row_ok;
   logic       row_err;
   logic       buf_we;
   logic       frame_end;
   logic       seq_err;
   cand_t      match_cand;
   plane_t     red_plane;
   plane_t     grn_plane;

   // Row strobe is active-low; a blank strobe (all high) is not a sample.
   assign row_sel   = ~bus.row_in;
   assign row_blank = (row_sel == 8'h00);
   assign row_multi = |(row_sel & (row_sel - 8'd1));
   assign row_idx   = onehot_index(row_sel);
   assign row_ok    = bus.scan_en && !row_blank && !row_multi;
   assign row_err   = bus.scan_en && row_multi;

   // Row 7 is classified straight from the bus on the edge that captures it.
   assign red_plane = {bus.colr_in, red_buf_q};
   assign grn_plane = {bus.colg_in, grn_buf_q};

   dz_glyph_match u_match (
      .red_plane  (red_plane),
      .grn_plane  (grn_plane),
      .cand_num   (match_cand.num),
      .cand_color (match_cand.color)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_HUNT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      if (row_err) begin
         state_d = ST_HUNT;
         exp_d   = '0;
      end else if (row_ok) begin
         case (state_q)
            ST_HUNT: begin
               if (row_idx == 3'd0) begin
                  state_d = ST_ASSEMBLE;
                  exp_d   = 3'd1;
               end
            end
            ST_ASSEMBLE: begin
               if (row_idx == exp_q) begin
                  if (exp_q == 3'd7) begin
                     state_d = ST_HUNT;
                     exp_d   = '0;
                  end else begin
                     exp_d = exp_q + 3'd1;
                  end
               end else if (row_idx == 3'd0) begin
                  exp_d = 3'd1;
               end else begin
                  state_d = ST_HUNT;
                  exp_d   = '0;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_comb begin
      buf_we    = 1'b0;
      frame_end = 1'b0;
      seq_err   = 1'b0;
      if (row_ok) begin
         case (state_q)
            ST_HUNT: buf_we = (row_idx == 3'd0);
            ST_ASSEMBLE: begin
               if (row_idx == exp_q) begin
                  buf_we    = 1'b1;
                  frame_end = (exp_q == 3'd7);
               end else begin
                  seq_err = 1'b1;
                  buf_we  = (row_idx == 3'd0);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      red_buf_d = red_buf_q;
      grn_buf_d = grn_buf_q;
      if (buf_we) begin
         for (int i = 0; i < 7; i++) begin
            if (row_idx == 3'(i)) begin
               red_buf_d[i] = bus.colr_in;
               grn_buf_d[i] = bus.colg_in;
            end
         end
      end

      cand_d       = frame_end ? match_cand : cand_q;
      frame_done_d = frame_end;
      err_row_d    = row_err;
      err_seq_d    = seq_err;

      // The candidate registered on the row-7 edge is scored on the following edge.
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      out_d   = out_q;
      valid_d = valid_q;
      if (frame_done_q) begin
         prev_d = cand_q;
         if (cand_q == prev_q) cnt_d = (cnt_q >= STABLE_CNT) ? STABLE_CNT : cnt_q + 3'd1;
         else                  cnt_d = 3'd1;
      end
      if (row_err || seq_err) begin
         cnt_d = '0;
      end else if (frame_done_q && (cnt_d == STABLE_CNT)) begin
         out_d   = cand_q;
         valid_d = 1'b1;
      end
   end

   // NOTE: the frame buffer is reset too, so a freshly reset decoder holds a well-defined blank frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q        <= '0;
         red_buf_q    <= '0;
         grn_buf_q    <= '0;
         cand_q       <= '0;
         prev_q       <= '0;
         out_q        <= '0;
         cnt_q        <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_row_q    <= 1'b0;
         err_seq_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         exp_q        <= exp_d;
         red_buf_q    <= red_buf_d;
         grn_buf_q    <= grn_buf_d;
         cand_q       <= cand_d;
         prev_q       <= prev_d;
         out_q        <= out_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         err_row_q    <= err_row_d;
         err_seq_q    <= err_seq_d;
      end
   end

   assign bus.num_out    = out_q.num;
   assign bus.color_out  = out_q.color;
   assign bus.num_valid  = valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err_row    = err_row_q;
   assign bus.err_seq    = err_seq_q;

endmodule
